csr_trap_unit: RTL and testbench

//   Parametrised RISC-V machine-mode CSR file with trap entry/return sequencing and hardware counters.

---
 rtl/csr_trap_unit.sv | 160 ++++++++++++++++
 tb/tb_csr_trap_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return sequencing and 64-bit cycle/instret counters.
// CSR reads return the pre-write value; trap and mret take precedence over CSR writes.
module csr_trap_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] VENDOR_ID = '0,
    parameter logic [XLEN-1:0] ARCH_ID   = '0,
    parameter logic [XLEN-1:0] IMP_ID    = '0,
    parameter logic [XLEN-1:0] MISA_VAL  = 'h40000100,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     address_i,
    input  logic            en_read_i,
    input  logic            en_write_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_out_o,
    output logic            illegal_o,
    input  logic            retire_i,
    input  logic            except_i,
    input  logic [XLEN-1:0] cause_i,
    input  logic [XLEN-1:0] except_pc_i,
    input  logic            mret_i,
    output logic            trap_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o,
    output logic            in_trap_o
);
    typedef enum logic {RUN, TRAP} state_t;

    state_t          r_state;
    logic            r_mie, r_mpie, r_trap, r_illegal;
    logic [XLEN-1:0] r_mie_csr, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mip, r_dout;
    logic [63:0]     r_mcycle, r_minstret;

    logic [XLEN-1:0] w_rdata, w_mstatus, w_base;
    logic            w_rd_ok, w_wr_ok, w_wr_go, w_mret_bad;
    logic [63:0]     w_wd64;

    assign w_wd64 = 64'(data_i);

    always_comb begin
        w_mstatus    = '0;
        w_mstatus[3] = r_mie;
        w_mstatus[7] = r_mpie;
    end

    // Decode shared by read and write; the write set excludes misa and the ID registers.
    always_comb begin
        w_rdata = '0;
        w_rd_ok = 1'b1;
        w_wr_ok = 1'b1;
        case (address_i)
            12'h300: w_rdata = w_mstatus;
            12'h301: begin w_rdata = MISA_VAL;  w_wr_ok = 1'b0; end
            12'h304: w_rdata = r_mie_csr;
            12'h305: w_rdata = r_mtvec;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h344: w_rdata = r_mip;
            12'hB00: w_rdata = r_mcycle[XLEN-1:0];
            12'hB02: w_rdata = r_minstret[XLEN-1:0];
            12'hB80: begin
                w_rdata = XLEN'(r_mcycle[63:32]);
                w_rd_ok = (XLEN == 32);
                w_wr_ok = (XLEN == 32);
            end
            12'hB82: begin
                w_rdata = XLEN'(r_minstret[63:32]);
                w_rd_ok = (XLEN == 32);
                w_wr_ok = (XLEN == 32);
            end
            12'hF11: begin w_rdata = VENDOR_ID; w_wr_ok = 1'b0; end
            12'hF12: begin w_rdata = ARCH_ID;   w_wr_ok = 1'b0; end
            12'hF13: begin w_rdata = IMP_ID;    w_wr_ok = 1'b0; end
            12'hF14: begin w_rdata = HART_ID;   w_wr_ok = 1'b0; end
            default: begin w_rd_ok = 1'b0;      w_wr_ok = 1'b0; end
        endcase
        if (!w_rd_ok) w_rdata = '0;
    end

    assign w_wr_go    = en_write_i && w_wr_ok && !except_i && !mret_i;
    assign w_mret_bad = mret_i && !except_i && (r_state == RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_trap     <= 1'b0;
            r_illegal  <= 1'b0;
            r_dout     <= '0;
            r_mie_csr  <= '0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mip      <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_trap <= except_i;
            if (en_read_i) r_dout <= w_rdata;
            if (en_read_i || en_write_i || mret_i)
                r_illegal <= (en_read_i && !w_rd_ok) || (en_write_i && !w_wr_ok) || w_mret_bad;

            if (except_i) begin
                r_state  <= TRAP;
                r_mepc   <= {except_pc_i[XLEN-1:2], 2'b00};
                r_mcause <= cause_i;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (mret_i && r_state == TRAP) begin
                r_state <= RUN;
                r_mie   <= r_mpie;
                r_mpie  <= 1'b1;
            end else if (w_wr_go) begin
                case (address_i)
                    12'h300: begin r_mie <= data_i[3]; r_mpie <= data_i[7]; end
                    12'h304: r_mie_csr  <= data_i;
                    12'h305: r_mtvec    <= data_i[1] ? {data_i[XLEN-1:2], 2'b00} : data_i;
                    12'h340: r_mscratch <= data_i;
                    12'h341: r_mepc     <= {data_i[XLEN-1:2], 2'b00};
                    12'h342: r_mcause   <= data_i;
                    12'h344: r_mip      <= data_i;
                    default: ;
                endcase
            end

            // A written half is replaced outright; the counter skips its increment that cycle.
            if (w_wr_go && address_i == 12'hB00)
                r_mcycle <= (XLEN == 64) ? w_wd64 : {r_mcycle[63:32], w_wd64[31:0]};
            else if (w_wr_go && address_i == 12'hB80)
                r_mcycle <= {w_wd64[31:0], r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr_go && address_i == 12'hB02)
                r_minstret <= (XLEN == 64) ? w_wd64 : {r_minstret[63:32], w_wd64[31:0]};
            else if (w_wr_go && address_i == 12'hB82)
                r_minstret <= {w_wd64[31:0], r_minstret[31:0]};
            else if (retire_i)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_pc_o = (r_mtvec[1:0] == 2'b01 && r_mcause[XLEN-1])
                     ? w_base + {r_mcause[XLEN-3:0], 2'b00} : w_base;

    assign data_out_o = r_dout;
    assign illegal_o  = r_illegal;
    assign trap_o     = r_trap;
    assign mepc_o     = r_mepc;
    assign mie_o      = r_mie;
    assign in_trap_o  = (r_state == TRAP);
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: reset, CSR access legality, traps, mret, counters.
module tb_csr_trap_unit;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [11:0]     address_i;
    logic            en_read_i, en_write_i, retire_i, except_i, mret_i;
    logic [XLEN-1:0] data_i, cause_i, except_pc_i;
    logic [XLEN-1:0] data_out_o, trap_pc_o, mepc_o;
    logic            illegal_o, trap_o, mie_o, in_trap_o;

    int n_tests = 0;
    int n_fail  = 0;

    csr_trap_unit #(
        .XLEN(XLEN), .HART_ID('h11), .VENDOR_ID('h22), .ARCH_ID('h33), .IMP_ID('h44),
        .MISA_VAL('h40000100), .MTVEC_RST('h100)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .en_read_i(en_read_i),
        .en_write_i(en_write_i), .data_i(data_i), .data_out_o(data_out_o),
        .illegal_o(illegal_o), .retire_i(retire_i), .except_i(except_i),
        .cause_i(cause_i), .except_pc_i(except_pc_i), .mret_i(mret_i), .trap_o(trap_o),
        .trap_pc_o(trap_pc_o), .mepc_o(mepc_o), .mie_o(mie_o), .in_trap_o(in_trap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        en_read_i = 0; en_write_i = 0; retire_i = 0; except_i = 0; mret_i = 0;
        address_i = '0; data_i = '0; cause_i = '0; except_pc_i = '0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
        address_i = a; data_i = d; en_write_i = 1;
        tick();
        idle();
    endtask

    task automatic csr_rd(input logic [11:0] a);
        address_i = a; en_read_i = 1;
        tick();
        idle();
    endtask

    task automatic take_trap(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause);
        except_i = 1; except_pc_i = pc; cause_i = cause;
        tick();
        idle();
    endtask

    task automatic do_mret();
        mret_i = 1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
        check("rst_in_trap", in_trap_o, 0);
        check("rst_trap", trap_o, 0);
        check("rst_mie", mie_o, 0);
        check("rst_mepc", mepc_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_dout", data_out_o, 0);
        check("rst_trap_pc", trap_pc_o, 'h100);
        tick();
        csr_rd(12'hB00);
        check("rst_mcycle", data_out_o, 1);
        csr_rd(12'h305);
        check("rst_mtvec", data_out_o, 'h100);

        // vectored interrupt trap
        csr_wr(12'h305, 'h8000_0101);
        take_trap('h400, 'h8000_0007);
        check("vec_trap_pulse", trap_o, 1);
        check("vec_trap_pc", trap_pc_o, 'h8000_011C);
        check("vec_in_trap", in_trap_o, 1);
        check("vec_mie", mie_o, 0);
        tick();
        check("vec_pulse_end", trap_o, 0);
        do_mret();
        check("vec_mret_run", in_trap_o, 0);
        check("vec_mret_mie", mie_o, 0);

        // sync exception with MIE set, then mret
        csr_wr(12'h300, 'h8);
        check("ms_mie_set", mie_o, 1);
        take_trap('h1002, 'h2);
        check("ex_mepc", mepc_o, 'h1000);
        check("ex_mie", mie_o, 0);
        check("ex_trap_pc", trap_pc_o, 'h8000_0100);
        csr_rd(12'h300);
        check("ex_mstatus", data_out_o, 'h80);
        check("ex_in_trap", in_trap_o, 1);
        do_mret();
        check("mret_mie", mie_o, 1);
        check("mret_in_trap", in_trap_o, 0);
        csr_rd(12'h300);
        check("mret_mstatus", data_out_o, 'h88);

        // nested trap
        csr_wr(12'h300, 0);
        take_trap('h3000, 'h5);
        take_trap('h3008, 'hB);
        check("nest_in_trap", in_trap_o, 1);
        check("nest_mepc", mepc_o, 'h3008);
        check("nest_pulse", trap_o, 1);
        csr_rd(12'h342);
        check("nest_mcause", data_out_o, 'hB);
        do_mret();

        // trap wins over a concurrent mepc write
        except_i = 1; except_pc_i = 'h2006; cause_i = 'h3;
        en_write_i = 1; address_i = 12'h341; data_i = 'hABCD;
        tick(); idle();
        check("prio_mepc", mepc_o, 'h2004);
        do_mret();

        // WARL fields
        csr_wr(12'h305, 'h203);
        csr_rd(12'h305);
        check("warl_mtvec", data_out_o, 'h200);
        csr_wr(12'h341, 'h307);
        check("warl_mepc", mepc_o, 'h304);
        csr_wr(12'h300, 'hFFFF_FFFF);
        csr_rd(12'h300);
        check("warl_mstatus", data_out_o, 'h88);

        // legality
        csr_wr(12'hF14, 'h55);
        check("ro_wr_illegal", illegal_o, 1);
        csr_rd(12'hF14);
        check("hart_id", data_out_o, 'h11);
        check("ro_rd_legal", illegal_o, 0);
        csr_rd(12'hF11);
        check("vendor_id", data_out_o, 'h22);
        csr_rd(12'h7C0);
        check("unmap_data", data_out_o, 0);
        check("unmap_illegal", illegal_o, 1);
        tick();
        check("illegal_hold", illegal_o, 1);
        csr_rd(12'h301);
        check("misa", data_out_o, 'h40000100);
        csr_wr(12'h301, 0);
        check("misa_wr_illegal", illegal_o, 1);
        csr_wr(12'h340, 'h1234);
        check("scratch_wr_legal", illegal_o, 0);
        csr_rd(12'h340);
        check("scratch_rd", data_out_o, 'h1234);
        en_read_i = 1; en_write_i = 1; address_i = 12'h340; data_i = 'h5678;
        tick(); idle();
        check("rw_old", data_out_o, 'h1234);
        csr_rd(12'h340);
        check("rw_new", data_out_o, 'h5678);
        do_mret();
        check("mret_run_illegal", illegal_o, 1);
        check("mret_run_state", in_trap_o, 0);

        // mcycle 64-bit wrap
        csr_wr(12'hB00, 'hFFFF_FFFF);
        csr_wr(12'hB80, 'hFFFF_FFFF);
        csr_rd(12'hB00);
        check("cyc_lo_max", data_out_o, 'hFFFF_FFFF);
        csr_rd(12'hB80);
        check("cyc_hi_wrap", data_out_o, 0);
        csr_rd(12'hB00);
        check("cyc_lo_wrap", data_out_o, 1);

        // high half moves only on low-half carry
        csr_wr(12'hB00, 'hFFFF_FFFD);
        csr_wr(12'hB80, 5);
        csr_rd(12'hB80);
        check("cyc_hi_a", data_out_o, 5);
        csr_rd(12'hB80);
        check("cyc_hi_b", data_out_o, 5);
        csr_rd(12'hB80);
        check("cyc_hi_c", data_out_o, 5);
        csr_rd(12'hB80);
        check("cyc_hi_carry", data_out_o, 6);

        // minstret: write suppresses increment, then retire count
        retire_i = 1; en_write_i = 1; address_i = 12'hB02; data_i = 7;
        tick(); idle();
        retire_i = 1;
        tick(); tick(); tick();
        idle();
        csr_rd(12'hB02);
        check("instret", data_out_o, 10);
        csr_rd(12'hB82);
        check("instret_hi", data_out_o, 0);

        // reset in the trap cycle
        csr_wr(12'h305, 'h0);
        except_i = 1; except_pc_i = 'h5000; cause_i = 'h2; rst_i = 1;
        tick(); idle(); rst_i = 0;
        check("rst_trap_state", in_trap_o, 0);
        check("rst_trap_pulse", trap_o, 0);
        check("rst_trap_mepc", mepc_o, 0);
        check("rst_trap_mtvec", trap_pc_o, 'h100);
        take_trap('h6000, 'h2);
        rst_i = 1;
        tick(); rst_i = 0;
        check("rst_mid_state", in_trap_o, 0);
        check("rst_mid_pulse", trap_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
